// File: rtl/hub75_bcm_driver_if.sv
// Pixel-fetch bus between the HUB75 scan driver (master) and a pixel source (slave).
// The source answers each request with one plane bit per colour for both half-panels.
interface hub75_bcm_driver_if #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5,
   parameter int BPC       = 8
);
   localparam int XW = $clog2(WIDTH);
   localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;

   logic                 pix_req;
   logic [XW-1:0]        pix_x;
   logic [ADDR_BITS-1:0] pix_row;
   logic [PW-1:0]        pix_plane;
   logic [2:0]           pix_rgb0;
   logic [2:0]           pix_rgb1;

   modport master (
      output pix_req,
      output pix_x,
      output pix_row,
      output pix_plane,
      input  pix_rgb0,
      input  pix_rgb1
   );

   modport slave (
      input  pix_req,
      input  pix_x,
      input  pix_row,
      input  pix_plane,
      output pix_rgb0,
      output pix_rgb1
   );
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 split-scan row driver using binary-coded modulation: one shift per bit-plane,
// display window BASE_TICKS << plane, scaled by a global brightness sampled per window.
module hub75_bcm_driver #(
   parameter int WIDTH         = 64,
   parameter int ADDR_BITS     = 5,
   parameter int BPC           = 8,
   parameter int BASE_TICKS    = 16,
   parameter int FETCH_LATENCY = 1
) (
   input  logic                 clk30,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           brightness,
   hub75_bcm_driver_if.master   pix,
   output logic [2:0]           led_rgb0,
   output logic [2:0]           led_rgb1,
   output logic [ADDR_BITS-1:0] led_addr,
   output logic                 led_blank,
   output logic                 led_latch,
   output logic                 led_sclk_ena,
   output logic                 frame_start,
   output logic [15:0]          frame_count
);
   localparam int XW = $clog2(WIDTH);
   localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int SW = XW + 2;
   localparam int CW = $clog2(BASE_TICKS) + BPC + 1;
   localparam int MW = CW + 9;

   localparam logic [SW-1:0] REQ_END    = SW'(WIDTH);
   localparam logic [SW-1:0] CAP_FIRST  = SW'(FETCH_LATENCY);
   localparam logic [SW-1:0] CAP_LAST   = SW'(WIDTH + FETCH_LATENCY - 1);
   localparam logic [SW-1:0] SHIFT_LAST = SW'(WIDTH + FETCH_LATENCY);
   localparam logic [PW-1:0] PLANE_LAST = PW'(BPC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_UNLATCH,
      S_DISPLAY
   } state_t;

   state_t               state_reg;
   state_t               state_next;

   logic [SW-1:0]        shift_cnt_reg;
   logic [CW-1:0]        disp_cnt_reg;
   logic [CW-1:0]        on_cycles_reg;
   logic [ADDR_BITS-1:0] row_reg;
   logic [PW-1:0]        plane_reg;
   logic [ADDR_BITS-1:0] addr_reg;
   logic [2:0]           rgb0_reg;
   logic [2:0]           rgb1_reg;
   logic [15:0]          frame_count_reg;

   logic [CW-1:0]        window;
   logic [MW-1:0]        on_product;
   logic                 shift_done;
   logic                 disp_done;
   logic                 capture;
   logic                 req_c;
   logic                 sclk_c;
   logic                 latch_c;
   logic                 blank_c;

   // Full-width product so low brightness on short planes rounds to zero, not wraps.
   assign window     = CW'(BASE_TICKS) << plane_reg;
   assign on_product = (MW'(brightness) + MW'(1)) * MW'(window);

   assign shift_done = (shift_cnt_reg == SHIFT_LAST);
   assign disp_done  = (disp_cnt_reg == (window - CW'(1)));
   assign capture    = (state_reg == S_SHIFT) &&
                       (shift_cnt_reg >= CAP_FIRST) && (shift_cnt_reg <= CAP_LAST);

   always_ff @(posedge clk30) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_c      = 1'b0;
      sclk_c     = 1'b0;
      latch_c    = 1'b0;
      blank_c    = 1'b1;
      case (state_reg)
         S_IDLE: begin
            if (enable) begin
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            req_c  = (shift_cnt_reg < REQ_END);
            // Each capture is clocked out by an sclk pulse in the following cycle.
            sclk_c = (shift_cnt_reg > CAP_FIRST);
            if (shift_done) begin
               state_next = S_BLANK;
            end
         end
         S_BLANK: begin
            state_next = S_LATCH;
         end
         S_LATCH: begin
            latch_c    = 1'b1;
            state_next = S_UNLATCH;
         end
         S_UNLATCH: begin
            state_next = S_DISPLAY;
         end
         S_DISPLAY: begin
            blank_c = (disp_cnt_reg >= on_cycles_reg);
            if (disp_done) begin
               state_next = enable ? S_SHIFT : S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         shift_cnt_reg   <= '0;
         disp_cnt_reg    <= '0;
         on_cycles_reg   <= '0;
         row_reg         <= '0;
         plane_reg       <= '0;
         addr_reg        <= '0;
         rgb0_reg        <= '0;
         rgb1_reg        <= '0;
         frame_count_reg <= '0;
      end else begin
         if ((state_reg == S_SHIFT) && !shift_done) begin
            shift_cnt_reg <= shift_cnt_reg + SW'(1);
         end else begin
            shift_cnt_reg <= '0;
         end

         if ((state_reg == S_DISPLAY) && !disp_done) begin
            disp_cnt_reg <= disp_cnt_reg + CW'(1);
         end else begin
            disp_cnt_reg <= '0;
         end

         if (capture) begin
            rgb0_reg <= pix.pix_rgb0;
            rgb1_reg <= pix.pix_rgb1;
         end

         // Row address changes while the panel is dark, ahead of the latch pulse.
         if ((state_reg == S_SHIFT) && shift_done) begin
            addr_reg <= row_reg;
         end

         if (state_reg == S_UNLATCH) begin
            on_cycles_reg <= CW'(on_product >> 8);
         end

         if ((state_reg == S_DISPLAY) && disp_done) begin
            if (plane_reg == PLANE_LAST) begin
               plane_reg <= '0;
               row_reg   <= row_reg + ADDR_BITS'(1);
               if (row_reg == '1) begin
                  frame_count_reg <= frame_count_reg + 16'd1;
               end
            end else begin
               plane_reg <= plane_reg + PW'(1);
            end
         end
      end
   end

   assign pix.pix_req   = req_c;
   assign pix.pix_x     = shift_cnt_reg[XW-1:0];
   assign pix.pix_row   = row_reg;
   assign pix.pix_plane = plane_reg;

   assign led_rgb0     = rgb0_reg;
   assign led_rgb1     = rgb1_reg;
   assign led_addr     = addr_reg;
   assign led_blank    = blank_c;
   assign led_latch    = latch_c;
   assign led_sclk_ena = sclk_c;
   assign frame_start  = req_c && (shift_cnt_reg == '0) && (row_reg == '0) && (plane_reg == '0);
   assign frame_count  = frame_count_reg;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver: small panel, scoreboarded shift data, BCM window,
// brightness, frame wrap and enable drop/resume checks.
module tb_hub75_bcm_driver;
   localparam int WIDTH      = 8;
   localparam int ADDR_BITS  = 2;
   localparam int BPC        = 3;
   localparam int BASE_TICKS = 4;
   localparam int FL         = 2;
   localparam int ROWS       = 1 << ADDR_BITS;
   localparam int OVERHEAD   = WIDTH + FL + 4;
   localparam int ROW_CYCLE  = BPC * OVERHEAD + BASE_TICKS * ((1 << BPC) - 1);
   localparam int DROP_SLOT  = 2 * BPC;

   logic                 clk30 = 1'b0;
   logic                 reset = 1'b1;
   logic                 enable = 1'b0;
   logic [7:0]           brightness = 8'd255;
   logic [2:0]           led_rgb0;
   logic [2:0]           led_rgb1;
   logic [ADDR_BITS-1:0] led_addr;
   logic                 led_blank;
   logic                 led_latch;
   logic                 led_sclk_ena;
   logic                 frame_start;
   logic [15:0]          frame_count;

   hub75_bcm_driver_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .BPC(BPC)) pix_if ();

   hub75_bcm_driver #(
      .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .BPC(BPC),
      .BASE_TICKS(BASE_TICKS), .FETCH_LATENCY(FL)
   ) dut (
      .clk30(clk30),
      .reset(reset),
      .enable(enable),
      .brightness(brightness),
      .pix(pix_if),
      .led_rgb0(led_rgb0),
      .led_rgb1(led_rgb1),
      .led_addr(led_addr),
      .led_blank(led_blank),
      .led_latch(led_latch),
      .led_sclk_ena(led_sclk_ena),
      .frame_start(frame_start),
      .frame_count(frame_count)
   );

   always #5 clk30 = ~clk30;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Pixel source: FL-stage pipeline returning x on the upper half, x^{plane[0],row} lower.
   logic [5:0] src_pipe [FL];
   always @(posedge clk30) begin
      src_pipe[0] <= pix_if.pix_req ?
                     {pix_if.pix_x[2:0] ^ {pix_if.pix_plane[0], pix_if.pix_row}, pix_if.pix_x[2:0]} :
                     6'd0;
      for (int i = 1; i < FL; i++) begin
         src_pipe[i] <= src_pipe[i-1];
      end
   end
   assign pix_if.pix_rgb0 = src_pipe[FL-1][2:0];
   assign pix_if.pix_rgb1 = src_pipe[FL-1][5:3];

   int         exp_x = 0;
   int         exp_row = 0;
   int         exp_plane = 0;
   int         fs_seen = 0;
   logic [5:0] sb_q [$];

   initial begin : monitor
      logic [5:0] exp_pair;
      forever begin
         @(negedge clk30);
         if (reset) begin
            exp_x = 0;
            exp_row = 0;
            exp_plane = 0;
            fs_seen = 0;
            sb_q.delete();
         end else begin
            if (pix_if.pix_req || frame_start) begin
               check("frame_start", frame_start,
                     int'(pix_if.pix_req && exp_x == 0 && exp_row == 0 && exp_plane == 0));
            end
            if (frame_start) fs_seen++;
            if (pix_if.pix_req) begin
               check("pix_x", pix_if.pix_x, exp_x);
               check("pix_row", pix_if.pix_row, exp_row);
               check("pix_plane", pix_if.pix_plane, exp_plane);
               sb_q.push_back({3'(exp_x ^ ((exp_plane % 2) * 4 + exp_row)), 3'(exp_x)});
               exp_x++;
               if (exp_x == WIDTH) begin
                  exp_x = 0;
                  exp_plane++;
                  if (exp_plane == BPC) begin
                     exp_plane = 0;
                     exp_row = (exp_row + 1) % ROWS;
                  end
               end
            end
            if (led_sclk_ena) begin
               if (sb_q.size() == 0) begin
                  check("sclk_underflow", 1, 0);
               end else begin
                  exp_pair = sb_q.pop_front();
                  check("led_rgb0", led_rgb0, exp_pair[2:0]);
                  check("led_rgb1", led_rgb1, exp_pair[5:3]);
               end
            end
         end
      end
   end

   task automatic wait_latch();
      bit seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk30);
         seen = led_latch;
      end
      if (!seen) check("latch_timeout", 0, 1);
   endtask

   // Starts in a LATCH cycle, runs to the next LATCH cycle.
   task automatic measure(input bit drop, output int iv, output int lows, output int first_low,
                          output int sclks, output int addr_blank);
      int prev_addr;
      iv = 0;
      lows = 0;
      first_low = -1;
      sclks = 0;
      addr_blank = -1;
      prev_addr = int'(led_addr);
      for (int c = 1; c <= 400 && iv == 0; c++) begin
         @(negedge clk30);
         if (c == 1) check("latch_width", led_latch, 0);
         if (led_latch) begin
            iv = c;
            addr_blank = prev_addr;
         end else begin
            if (!led_blank) begin
               lows++;
               if (first_low < 0) first_low = c;
            end
            if (led_sclk_ena) sclks++;
            if (drop && pix_if.pix_req) enable = 1'b0;
            prev_addr = int'(led_addr);
         end
      end
      if (iv == 0) check("latch_timeout", 0, 1);
   endtask

   function automatic int bri_of(input int row_idx);
      case (row_idx % 4)
         0:       return 255;
         1:       return 127;
         2:       return 100;
         default: return 0;
      endcase
   endfunction

   initial begin
      int iv, lows, first_low, sclks, addr_blank, reqs, row_sum;
      int r, p, b, w, exp_n;
      row_sum = 0;

      repeat (2) @(posedge clk30);
      @(negedge clk30);
      check("rst_blank", led_blank, 1);
      check("rst_req", pix_if.pix_req, 0);
      check("rst_latch", led_latch, 0);
      check("rst_sclk", led_sclk_ena, 0);
      check("rst_rgb0", led_rgb0, 0);
      check("rst_rgb1", led_rgb1, 0);
      check("rst_addr", led_addr, 0);
      check("rst_frames", frame_count, 0);
      check("rst_fstart", frame_start, 0);

      @(posedge clk30); #1;
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk30);
      check("req_before_start", pix_if.pix_req, 0);
      @(negedge clk30);
      check("first_req", pix_if.pix_req, 1);
      check("first_req_x", pix_if.pix_x, 0);

      repeat (4) @(posedge clk30);
      #1 reset = 1'b1;
      @(negedge clk30);
      check("pre_reset_rgb0", led_rgb0, 1);
      @(posedge clk30); #1;
      @(negedge clk30);
      check("midshift_rst_blank", led_blank, 1);
      check("midshift_rst_req", pix_if.pix_req, 0);
      check("midshift_rst_sclk", led_sclk_ena, 0);
      check("midshift_rst_rgb0", led_rgb0, 0);
      check("midshift_rst_rgb1", led_rgb1, 0);
      @(posedge clk30); #1;
      reset = 1'b0;

      wait_latch();
      for (int k = 0; k <= 8 * BPC; k++) begin
         r = (k / BPC) % ROWS;
         p = k % BPC;
         check("latch_addr", led_addr, r);
         check("frame_count", frame_count, k / (BPC * ROWS));
         if (k == 8 * BPC) break;
         b = bri_of(k / BPC);
         brightness = 8'(b);
         w = BASE_TICKS << p;
         exp_n = ((b + 1) * w) >> 8;
         if (p == 0) row_sum = 0;
         if (k == DROP_SLOT + 1) begin
            lows = 0;
            reqs = 0;
            for (int c = 1; c <= 40; c++) begin
               @(negedge clk30);
               if (!led_blank) lows++;
               if (pix_if.pix_req) reqs++;
            end
            check("idle_on_cycles", lows, exp_n);
            check("idle_req", reqs, 0);
            check("idle_blank", led_blank, 1);
            enable = 1'b1;
            @(negedge clk30);
            check("resume_req", pix_if.pix_req, 1);
            check("resume_row", pix_if.pix_row, 2);
            check("resume_plane", pix_if.pix_plane, 2);
            check("resume_x", pix_if.pix_x, 0);
            wait_latch();
         end else begin
            measure(k == DROP_SLOT, iv, lows, first_low, sclks, addr_blank);
            check("plane_interval", iv, w + OVERHEAD);
            check("on_cycles", lows, exp_n);
            check("on_start", first_low, (exp_n > 0) ? 2 : -1);
            check("sclk_count", sclks, WIDTH);
            check("addr_in_blank", addr_blank, ((k + 1) / BPC) % ROWS);
            row_sum += iv;
            if (p == BPC - 1 && (k / BPC) != 2) check("row_cycle", row_sum, ROW_CYCLE);
         end
      end
      check("frame_start_pulses", fs_seen, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
